// File: rtl/scan_loader_pkg.sv
// Shared types and sizing for the scan-chain RAM loader.
// The optional feature is selected by SCAN_LOADER_AUTOINC_EN (see scan_mem_loader).
package scan_loader_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  // One extra bit so the counter can never wrap inside the longest field.
  function automatic int cnt_width(input int a, input int d);
    return $clog2((a > d) ? a : d) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(ADDR_W_DEF, DATA_W_DEF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    RDREQ = 3'd4,
    RDCAP = 3'd5,
    SHOUT = 3'd6
  } state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Shift register with serial-in/parallel-out and parallel-load/serial-out (MSB first).
// Parallel load takes priority over shifting.
module scan_shift_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         serial_in,
  input  logic         load_en,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] q,
  output logic         serial_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[W-2:0], serial_in};
    end
  end

  assign serial_out = q[W-1];

endmodule

// File: rtl/scan_mem_loader.sv
// Serial scan-chain loader that writes/reads instruction or data RAM words.
// Define SCAN_LOADER_AUTOINC_EN to stream consecutive write words without re-sending the address.
module scan_mem_loader
  import scan_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              shift_clk,
  input  logic              reset_ctrl_n,
  input  logic              memory_load_enable,
  input  logic              scan_in,
  input  logic              read,
  input  logic              inst_ram_load,
  output logic              scan_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              im_we,
  output logic              dm_we,
  output logic              mem_re,
  output logic              busy,
  output state_t            fsm_state
);

  localparam int CNT_W = cnt_width(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_W - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               is_read, is_read_n;
  logic               is_inst, is_inst_n;
  logic               rd_flag;
  logic [ADDR_W-1:0]  mem_addr_n, addr_q, addr_next;
  logic [DATA_W-1:0]  mem_wdata_n, data_q, data_next, rd_q;
  logic               addr_shift, data_shift;
  logic               addr_so, data_so, rd_so;
  logic               unused_bits;

  scan_shift_reg #(.W(ADDR_W)) u_addr_sr (
    .clk(shift_clk), .rst_n(reset_ctrl_n), .shift_en(addr_shift), .serial_in(scan_in),
    .load_en(1'b0), .load_data('0), .q(addr_q), .serial_out(addr_so)
  );

  scan_shift_reg #(.W(DATA_W)) u_data_sr (
    .clk(shift_clk), .rst_n(reset_ctrl_n), .shift_en(data_shift), .serial_in(scan_in),
    .load_en(1'b0), .load_data('0), .q(data_q), .serial_out(data_so)
  );

  scan_shift_reg #(.W(DATA_W)) u_read_sr (
    .clk(shift_clk), .rst_n(reset_ctrl_n), .shift_en(state == SHOUT), .serial_in(1'b0),
    .load_en(state == RDCAP), .load_data(mem_rdata), .q(rd_q), .serial_out(rd_so)
  );

  // The field's last bit is still on scan_in, so the committed word includes it directly.
  assign addr_next   = {addr_q[ADDR_W-2:0], scan_in};
  assign data_next   = {data_q[DATA_W-2:0], scan_in};
  assign unused_bits = ^{addr_so, data_so, addr_q[ADDR_W-1], data_q[DATA_W-1], rd_q};
  assign rd_flag     = (cnt == '0) ? read : is_read;

  always_ff @(posedge shift_clk or negedge reset_ctrl_n) begin
    if (!reset_ctrl_n) begin
      state     <= IDLE;
      cnt       <= '0;
      is_read   <= 1'b0;
      is_inst   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      is_read   <= is_read_n;
      is_inst   <= is_inst_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

  // Losing memory_load_enable mid-field returns to IDLE; committed address/data registers hold.
  always_comb begin
    state_n     = state;
    cnt_n       = '0;
    is_read_n   = is_read;
    is_inst_n   = is_inst;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    addr_shift  = 1'b0;
    data_shift  = 1'b0;
    case (state)
      IDLE: begin
        if (memory_load_enable) begin
          state_n    = ADDR;
          cnt_n      = CNT_W'(1);
          is_read_n  = read;
          is_inst_n  = inst_ram_load;
          addr_shift = 1'b1;
        end
      end
      ADDR: begin
        if (!memory_load_enable) begin
          state_n = IDLE;
        end else begin
          addr_shift = 1'b1;
          if (cnt == '0) begin
            is_read_n = read;
            is_inst_n = inst_ram_load;
          end
          if (cnt == LAST_A) begin
            mem_addr_n = addr_next;
            state_n    = rd_flag ? RDREQ : DATA;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (!memory_load_enable) begin
          state_n = IDLE;
        end else begin
          data_shift = 1'b1;
          if (cnt == LAST_D) begin
            mem_wdata_n = data_next;
            state_n     = WRITE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        if (!memory_load_enable) begin
          state_n = IDLE;
        end else begin
`ifdef SCAN_LOADER_AUTOINC_EN
          state_n    = DATA;
          mem_addr_n = mem_addr + ADDR_W'(1);
`else
          state_n    = ADDR;
`endif
        end
      end
      RDREQ: state_n = memory_load_enable ? RDCAP : IDLE;
      RDCAP: state_n = memory_load_enable ? SHOUT : IDLE;
      SHOUT: begin
        if (!memory_load_enable || cnt == LAST_D) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign im_we     = (state == WRITE) && is_inst;
  assign dm_we     = (state == WRITE) && !is_inst;
  assign mem_re    = (state == RDREQ);
  assign scan_out  = (state == SHOUT) && rd_so;
  assign fsm_state = state;

endmodule

// File: tb/tb_scan_mem_loader.sv
// Directed + randomized bench for scan_mem_loader with a word-level RAM reference model.
// Expectations for the streaming burst depend on SCAN_LOADER_AUTOINC_EN.
module tb_scan_mem_loader;
  import scan_loader_pkg::*;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int WQ = 1 + AW + DW;

  logic          shift_clk, reset_ctrl_n, memory_load_enable, scan_in, read, inst_ram_load;
  logic          scan_out, im_we, dm_we, mem_re, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  state_t        fsm_state;

  logic [DW-1:0] im_ram [2**AW];
  logic [DW-1:0] dm_ram [2**AW];
  logic [DW-1:0] ref_im [2**AW];
  logic [DW-1:0] ref_dm [2**AW];
  logic [WQ-1:0] exp_q[$];
  logic [WQ-1:0] exp_w;
  logic [DW-1:0] last_wdata;
  logic          rd_inst;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            re_count = 0;

  scan_mem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .shift_clk(shift_clk), .reset_ctrl_n(reset_ctrl_n), .memory_load_enable(memory_load_enable),
    .scan_in(scan_in), .read(read), .inst_ram_load(inst_ram_load), .scan_out(scan_out),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .im_we(im_we),
    .dm_we(dm_we), .mem_re(mem_re), .busy(busy), .fsm_state(fsm_state)
  );

  initial begin
    shift_clk = 1'b0;
    forever #5 shift_clk = ~shift_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // External RAMs: writes on strobe, read data valid the cycle after mem_re.
  always @(posedge shift_clk) begin
    if (im_we) im_ram[mem_addr] <= mem_wdata;
    if (dm_we) dm_ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= rd_inst ? im_ram[mem_addr] : dm_ram[mem_addr];
  end

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge shift_clk) begin
    if (reset_ctrl_n && (im_we || dm_we || mem_re))
      check("strobe_onehot", 64'($countones({im_we, dm_we, mem_re})), 1);
    if (reset_ctrl_n && (im_we || dm_we)) begin
      check("write_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("write_txn", {im_we, mem_addr, mem_wdata}, exp_w);
      end
    end
    if (reset_ctrl_n && mem_re) re_count++;
  end

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge shift_clk);
      scan_in = v[i];
    end
  endtask

  task automatic begin_txn(input logic rd, input logic inst, input logic [AW-1:0] addr);
    @(negedge shift_clk);
    memory_load_enable = 1'b1;
    read               = rd;
    inst_ram_load      = inst;
    scan_in            = addr[AW-1];
    send_bits(64'(addr), AW - 1);
  endtask

  task automatic write_word(input logic inst, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_q.push_back({inst, addr, data});
    if (inst) ref_im[addr] = data;
    else      ref_dm[addr] = data;
    last_wdata = data;
    begin_txn(1'b0, inst, addr);
    send_bits(64'(data), DW);
    @(negedge shift_clk);
    memory_load_enable = 1'b0;
    @(negedge shift_clk);
    check("wr_idle", busy, 0);
    check("wr_drained", 64'(exp_q.size()), 0);
  endtask

  task automatic read_word(input logic inst, input logic [AW-1:0] addr);
    logic [DW-1:0] exp;
    int re0;
    exp     = inst ? ref_im[addr] : ref_dm[addr];
    rd_inst = inst;
    re0     = re_count;
    begin_txn(1'b1, inst, addr);
    @(negedge shift_clk);
    check("rd_req_strobe", mem_re, 1);
    check("rd_req_quiet", scan_out, 0);
    @(negedge shift_clk);
    check("rd_cap_quiet", {mem_re, scan_out}, 0);
    for (int i = DW - 1; i >= 0; i--) begin
      @(negedge shift_clk);
      check($sformatf("rd_bit%0d", i), scan_out, exp[i]);
    end
    memory_load_enable = 1'b0;
    @(negedge shift_clk);
    check("rd_done_idle", {busy, scan_out}, 0);
    check("rd_single_re", 64'(re_count - re0), 1);
  endtask

  logic          r_inst [6];
  logic [AW-1:0] r_addr [6];
  logic [DW-1:0] r_data [6];

  initial begin
    reset_ctrl_n = 1'b0; memory_load_enable = 1'b0; scan_in = 1'b0;
    read = 1'b0; inst_ram_load = 1'b0; rd_inst = 1'b0; last_wdata = '0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_scan_out", scan_out, 0);
    check("rst_strobes", {im_we, dm_we, mem_re}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_state", fsm_state, IDLE);
    repeat (2) @(negedge shift_clk);
    reset_ctrl_n = 1'b1;

    // Basic write and read-back in both RAMs.
    write_word(1'b0, 11'h005, 32'hDEADBEEF);
    write_word(1'b1, 11'h005, 32'h12345678);
    read_word(1'b1, 11'h005);
    read_word(1'b0, 11'h005);

    // Abort after 16 data bits: no strobe, write-data register untouched.
    begin_txn(1'b0, 1'b0, 11'h123);
    send_bits(64'h0000_F0F0, 16);
    @(negedge shift_clk);
    memory_load_enable = 1'b0;
    @(negedge shift_clk);
    check("abort_busy", busy, 0);
    check("abort_wdata", mem_wdata, last_wdata);

    // Streaming burst: address 7FF followed by two data words.
    exp_q.push_back({1'b0, 11'h7FF, 32'hA5A5A5A5});
    ref_dm[11'h7FF] = 32'hA5A5A5A5;
    last_wdata      = 32'hA5A5A5A5;
`ifdef SCAN_LOADER_AUTOINC_EN
    exp_q.push_back({1'b0, 11'h000, 32'h5A5A5A5A});
    ref_dm[11'h000] = 32'h5A5A5A5A;
    last_wdata      = 32'h5A5A5A5A;
`endif
    begin_txn(1'b0, 1'b0, 11'h7FF);
    send_bits(64'hA5A5A5A5, DW);
    @(negedge shift_clk);
    scan_in = 1'b0;
    send_bits(64'h5A5A5A5A, DW);
    @(negedge shift_clk);
    memory_load_enable = 1'b0;
    @(negedge shift_clk);
    check("burst_idle", busy, 0);
    check("burst_drained", 64'(exp_q.size()), 0);
    check("burst_wdata", mem_wdata, last_wdata);
    read_word(1'b0, 11'h7FF);
`ifdef SCAN_LOADER_AUTOINC_EN
    read_word(1'b0, 11'h000);
`endif

    // Reset between edges in the middle of shifting out 12345678.
    rd_inst = 1'b1;
    begin_txn(1'b1, 1'b1, 11'h005);
    repeat (2) @(negedge shift_clk);
    for (int i = DW - 1; i >= DW - 4; i--) begin
      @(negedge shift_clk);
      check($sformatf("pre_rst_bit%0d", i), scan_out, ref_im[11'h005][i]);
    end
    #2 reset_ctrl_n = 1'b0;
    #1;
    check("mid_rst_scan_out", scan_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_strobes", {im_we, dm_we, mem_re}, 0);
    check("mid_rst_regs", {mem_addr, mem_wdata}, 0);
    memory_load_enable = 1'b0;
    @(negedge shift_clk);
    reset_ctrl_n = 1'b1;
    read_word(1'b0, 11'h005);

    // Random writes, then read back newest-first.
    for (int k = 0; k < 6; k++) begin
      r_inst[k] = 1'($urandom_range(0, 1));
      r_addr[k] = AW'($urandom_range(0, 2**AW - 1));
      r_data[k] = $urandom;
      write_word(r_inst[k], r_addr[k], r_data[k]);
    end
    for (int k = 5; k >= 0; k--) read_word(r_inst[k], r_addr[k]);

    repeat (2) @(negedge shift_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
